// File: rtl/johnson_pkg.sv
// ============================================================================
// Module : johnson_pkg
// Brief  : Shared FSM state type and Johnson counter step/decode helpers.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package johnson_pkg;

  localparam int c_JC_MAX_W = 32;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Shift left, feeding the inverted MSB into bit 0; bits at or above w are zeroed.
  function automatic logic [c_JC_MAX_W-1:0] jc_next(input logic [c_JC_MAX_W-1:0] q,
                                                    input int w);
    logic [c_JC_MAX_W-1:0] r;
    r    = q << 1;
    r[0] = ~q[w-1];
    for (int i = 0; i < c_JC_MAX_W; i++) begin
      if (i >= w) r[i] = 1'b0;
    end
    return r;
  endfunction

  // Ones-filled states map to their popcount; zeros-filled states to 2w - popcount.
  function automatic int jc_idx(input logic [c_JC_MAX_W-1:0] q, input int w);
    int ones;
    ones = 0;
    for (int i = 0; i < c_JC_MAX_W; i++) begin
      if (i < w && q[i]) ones++;
    end
    if (q[0] || ones == 0) return ones;
    return 2 * w - ones;
  endfunction

endpackage

`default_nettype wire

// File: rtl/johnson_seq_ctrl_core.sv
// ============================================================================
// Module : johnson_core
// Brief  : Johnson counter register with enable and synchronous clear.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module johnson_core
  import johnson_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (en) begin
      r_q <= WIDTH'(jc_next(c_JC_MAX_W'(r_q), WIDTH));
    end
  end

  assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/johnson_seq_ctrl.sv
// ============================================================================
// Module : johnson_seq_ctrl
// Brief  : One-shot / continuous run controller with phase decode for a
//          Johnson counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module johnson_seq_ctrl
  import johnson_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8,
  parameter int IDX_W = $clog2(2 * WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [CNT_W-1:0]   steps,
  input  logic               clr,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic [WIDTH-1:0]   q,
  output logic [2*WIDTH-1:0] phase,
  output logic [IDX_W-1:0]   phase_idx
);

  state_t           r_state, w_state_nx;
  logic [CNT_W-1:0] r_rem, w_rem_nx;
  logic             r_cont, w_cont_nx;
  logic             r_busy, w_busy_nx;
  logic             r_done, w_done_nx;
  logic             r_aborted, w_aborted_nx;
  logic             w_en, w_clr;

  johnson_core #(.WIDTH(WIDTH)) u_core (
    .clk (clk),
    .rst (rst),
    .en  (w_en),
    .clr (w_clr),
    .q   (q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_rem     <= '0;
      r_cont    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_rem     <= w_rem_nx;
      r_cont    <= w_cont_nx;
      r_busy    <= w_busy_nx;
      r_done    <= w_done_nx;
      r_aborted <= w_aborted_nx;
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_rem_nx     = r_rem;
    w_cont_nx    = r_cont;
    w_busy_nx    = r_busy;
    w_done_nx    = 1'b0;
    w_aborted_nx = 1'b0;
    w_en         = 1'b0;
    w_clr        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // stop outranks start; clr only applies when no run is requested
        if (stop) begin
          w_state_nx = ST_IDLE;
        end else if (start && !mode && steps != '0) begin
          w_rem_nx   = steps;
          w_cont_nx  = 1'b0;
          w_state_nx = ST_RUN;
          w_busy_nx  = 1'b1;
        end else if (start && !mode) begin
          w_done_nx = 1'b1;
        end else if (start) begin
          w_cont_nx  = 1'b1;
          w_state_nx = ST_RUN;
          w_busy_nx  = 1'b1;
        end else if (clr) begin
          w_clr = 1'b1;
        end
      end
      ST_RUN: begin
        if (stop) begin
          w_state_nx   = ST_IDLE;
          w_busy_nx    = 1'b0;
          w_aborted_nx = 1'b1;
        end else begin
          w_en = 1'b1;
          if (!r_cont) begin
            w_rem_nx = r_rem - 1'b1;
            if (r_rem == CNT_W'(1)) begin
              w_state_nx = ST_IDLE;
              w_busy_nx  = 1'b0;
              w_done_nx  = 1'b1;
            end
          end
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_busy_nx  = 1'b0;
      end
    endcase
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign aborted   = r_aborted;
  assign phase_idx = IDX_W'(jc_idx(c_JC_MAX_W'(q), WIDTH));
  assign phase     = {{(2*WIDTH-1){1'b0}}, 1'b1} << phase_idx;

endmodule

`default_nettype wire

// File: tb/tb_johnson_seq_ctrl.sv
// Testbench for johnson_seq_ctrl: directed scenarios plus randomized run
// checked against a phase-index reference model.
`default_nettype none

module tb_johnson_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, stop, mode, clr;
  logic [7:0] steps;
  logic       busy, done, aborted;
  logic [3:0] q;
  logic [7:0] phase;
  logic [2:0] phase_idx;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: phase position 0..7, run flags
  int m_idx, m_rem;
  bit m_busy, m_cont, m_done, m_ab;

  johnson_seq_ctrl #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
    .steps(steps), .clr(clr), .busy(busy), .done(done), .aborted(aborted),
    .q(q), .phase(phase), .phase_idx(phase_idx)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] qof(input int idx);
    if (idx <= 4) return 4'((1 << idx) - 1);
    return 4'hF & ~4'((1 << (idx - 4)) - 1);
  endfunction

  task automatic model_reset();
    m_idx = 0; m_rem = 0; m_busy = 0; m_cont = 0; m_done = 0; m_ab = 0;
  endtask

  task automatic idle_in();
    start = 0; stop = 0; mode = 0; clr = 0; steps = 8'd0;
  endtask

  // one rising edge: model consumes the inputs present at the edge
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_done = 0; m_ab = 0;
      if (!m_busy) begin
        if (stop) begin
        end else if (start && !mode && steps > 0) begin
          m_rem = steps; m_busy = 1; m_cont = 0;
        end else if (start && !mode) begin
          m_done = 1;
        end else if (start) begin
          m_busy = 1; m_cont = 1;
        end else if (clr) begin
          m_idx = 0;
        end
      end else if (stop) begin
        m_busy = 0; m_ab = 1;
      end else begin
        m_idx = (m_idx + 1) % 8;
        if (!m_cont) begin
          m_rem--;
          if (m_rem == 0) begin m_busy = 0; m_done = 1; end
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    idle_in();
    rst = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (q !== 4'b0000 || phase !== 8'b00000001 || busy !== 0 || done !== 0 || aborted !== 0) begin
      n_fail++;
      $display("FAIL reset_held: q=%b phase=%b busy=%b done=%b ab=%b required q=0000 phase=00000001 flags 0",
               q, phase, busy, done, aborted);
    end
    rst = 1;
    tick();
    n_checks++;
    if (q !== 4'b0000 || phase !== 8'b00000001 || busy !== 0 || done !== 0 || aborted !== 0) begin
      n_fail++;
      $display("FAIL reset_release: q=%b phase=%b busy=%b done=%b ab=%b required unchanged",
               q, phase, busy, done, aborted);
    end
  endtask

  task automatic test_oneshot();
    int nb, nd;
    nb = 0; nd = 0;
    start = 1; mode = 0; steps = 8'd5;
    tick();
    idle_in();
    steps = 8'd9; mode = 1;  // mid-run changes must have no effect
    for (int i = 0; i < 7; i++) begin
      if (busy) nb++;
      if (done) nd++;
      if (i == 5) begin
        n_checks++;
        if (done !== 1'b1) begin
          n_fail++;
          $display("FAIL oneshot_done_edge: done=%b required 1 after edge k+5", done);
        end
      end
      tick();
    end
    idle_in();
    n_checks++;
    if (nb != 5 || nd != 1) begin
      n_fail++;
      $display("FAIL oneshot_counts: busy_cycles=%0d done_cycles=%0d required 5 and 1", nb, nd);
    end
    n_checks++;
    if (q !== 4'b1110 || phase_idx !== 3'd5 || phase !== 8'b00100000) begin
      n_fail++;
      $display("FAIL oneshot_end: q=%b idx=%0d phase=%b required 1110 5 00100000", q, phase_idx, phase);
    end
  endtask

  task automatic test_wrap();
    int nd;
    bit saw0;
    nd = 0; saw0 = 0;
    start = 1; mode = 0; steps = 8'd4;
    tick();
    idle_in();
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) nd++;
      if (q == 4'b0000) saw0 = 1;
    end
    n_checks++;
    if (q !== 4'b0001 || phase_idx !== 3'd1 || nd != 1 || !saw0) begin
      n_fail++;
      $display("FAIL wrap: q=%b idx=%0d dones=%0d saw0000=%0d required 0001 1 1 1", q, phase_idx, nd, saw0);
    end
  endtask

  task automatic test_clr();
    clr = 1;
    tick();
    clr = 0;
    n_checks++;
    if (q !== 4'b0000) begin
      n_fail++;
      $display("FAIL clr_idle: q=%b required 0000", q);
    end
  endtask

  task automatic test_cont_stop();
    int nd;
    nd = 0;
    start = 1; mode = 1;
    tick();
    idle_in();
    for (int i = 0; i < 11; i++) begin
      tick();
      if (done) nd++;
    end
    stop = 1;
    tick();
    stop = 0;
    n_checks++;
    if (q !== 4'b0111 || phase_idx !== 3'd3 || aborted !== 1 || done !== 0 || busy !== 0 || nd != 0) begin
      n_fail++;
      $display("FAIL cont_stop: q=%b idx=%0d ab=%b done=%b busy=%b dones=%0d required 0111 3 1 0 0 0",
               q, phase_idx, aborted, done, busy, nd);
    end
    tick();
    n_checks++;
    if (aborted !== 0 || q !== 4'b0111) begin
      n_fail++;
      $display("FAIL cont_stop_pulse: ab=%b q=%b required 0 0111", aborted, q);
    end
  endtask

  task automatic test_clr_in_run();
    clr = 1;
    tick();
    clr = 0;
    start = 1; mode = 0; steps = 8'd3;
    tick();
    start = 0; clr = 1;
    tick();
    clr = 0;
    n_checks++;
    if (q !== 4'b0001 || busy !== 1) begin
      n_fail++;
      $display("FAIL clr_in_run: q=%b busy=%b required 0001 1", q, busy);
    end
    tick(); tick();
    n_checks++;
    if (q !== 4'b0111 || done !== 1) begin
      n_fail++;
      $display("FAIL clr_in_run_end: q=%b done=%b required 0111 1", q, done);
    end
    tick();
  endtask

  task automatic test_steps_zero();
    logic [3:0] q0;
    q0 = q;
    start = 1; mode = 0; steps = 8'd0;
    tick();
    idle_in();
    n_checks++;
    if (done !== 1 || busy !== 0 || q !== q0) begin
      n_fail++;
      $display("FAIL steps_zero: done=%b busy=%b q=%b required 1 0 %b", done, busy, q, q0);
    end
    tick();
    n_checks++;
    if (done !== 0 || busy !== 0 || q !== q0) begin
      n_fail++;
      $display("FAIL steps_zero_after: done=%b busy=%b q=%b required 0 0 %b", done, busy, q, q0);
    end
  endtask

  task automatic test_start_with_stop();
    logic [3:0] q0;
    q0 = q;
    start = 1; stop = 1; mode = 0; steps = 8'd4;
    tick();
    idle_in();
    tick();
    n_checks++;
    if (busy !== 0 || done !== 0 || aborted !== 0 || q !== q0) begin
      n_fail++;
      $display("FAIL start_with_stop: busy=%b done=%b ab=%b q=%b required 0 0 0 %b", busy, done, aborted, q, q0);
    end
  endtask

  task automatic test_stop_on_last();
    int i0;
    i0 = m_idx;
    start = 1; mode = 0; steps = 8'd3;
    tick();
    idle_in();
    tick(); tick();
    stop = 1;
    tick();
    stop = 0;
    n_checks++;
    if (q !== qof((i0 + 2) % 8) || aborted !== 1 || done !== 0 || busy !== 0) begin
      n_fail++;
      $display("FAIL stop_on_last: q=%b ab=%b done=%b busy=%b required %b 1 0 0",
               q, aborted, done, busy, qof((i0 + 2) % 8));
    end
    tick();
  endtask

  task automatic test_reset_midrun();
    start = 1; mode = 1;
    tick();
    idle_in();
    tick(); tick();
    #2 rst = 0;
    #1;
    model_reset();
    n_checks++;
    if (q !== 4'b0000 || busy !== 0 || phase !== 8'b00000001) begin
      n_fail++;
      $display("FAIL reset_midrun: q=%b busy=%b phase=%b required 0000 0 00000001", q, busy, phase);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    tick();
    n_checks++;
    if (q !== 4'b0000 || busy !== 0 || done !== 0 || aborted !== 0) begin
      n_fail++;
      $display("FAIL reset_midrun_release: q=%b busy=%b done=%b ab=%b required 0000 0 0 0", q, busy, done, aborted);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      start = ($urandom_range(0, 3) == 0);
      stop  = ($urandom_range(0, 11) == 0);
      clr   = ($urandom_range(0, 7) == 0);
      mode  = ($urandom_range(0, 3) == 0);
      steps = 8'($urandom_range(0, 12));
      tick();
      n_checks++;
      if (q !== qof(m_idx) || phase_idx !== 3'(m_idx) || phase !== 8'(1 << m_idx) ||
          busy !== m_busy || done !== m_done || aborted !== m_ab || (done && aborted)) begin
        n_fail++;
        $display("FAIL random_cycle%0d: q=%b idx=%0d phase=%b busy=%b done=%b ab=%b required %b %0d %b %b %b %b",
                 c, q, phase_idx, phase, busy, done, aborted,
                 qof(m_idx), m_idx, 8'(1 << m_idx), m_busy, m_done, m_ab);
      end
    end
    idle_in();
  endtask

  initial begin
    idle_in();
    rst = 0;
    test_reset();
    test_oneshot();
    test_wrap();
    test_clr();
    test_cont_stop();
    test_clr_in_run();
    test_steps_zero();
    test_start_with_stop();
    test_stop_on_last();
    test_reset_midrun();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/johnson_seq_ctrl.md
Name: johnson_seq_ctrl

Overview:
- Run controller for a Johnson counter datapath.
- Sequences it through a programmed number of steps (one-shot) or free-runs it (continuous), with a start/stop/done handshake.
- Decodes the counter state into a one-hot phase vector and a binary phase index for downstream phase-driven logic.
- Owns the counter register through one sub-module.

Parameters:
- WIDTH, 4: Johnson counter width; cycle length 2*WIDTH states.
- CNT_W, 8: width of step-count input and internal remaining-step counter.
- IDX_W, $clog2(2*WIDTH): width of phase_idx (derived; not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  request run; sampled only in IDLE.
- stop  in  1  abort run / stop continuous mode.
- mode  in  1  0 = one-shot (steps), 1 = continuous; latched at start.
- steps  in  CNT_W  number of advances for one-shot; latched at start.
- clr  in  1  synchronous clear of q to all-zero; honoured only in IDLE.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse on one-shot completion.
- aborted  out  1  one-cycle pulse when stop ends a run.
- q  out  WIDTH  Johnson counter state.
- phase  out  2*WIDTH  one-hot decode of q.
- phase_idx  out  IDX_W  binary index of current phase.

Behaviour:
- Reset (rst=0, async): state=IDLE, q=0, remaining=0, busy=0, done=0, aborted=0, phase=1 (bit0), phase_idx=0.
- Counter step: q_next = {q[WIDTH-2:0], ~q[WIDTH-1]}.
  - WIDTH=4 sequence: 0000,0001,0011,0111,1111,1110,1100,1000, then wraps to 0000.
- Phase index:
  - q with k ones filled from LSB (k = 0..WIDTH) -> idx k.
  - q with k zeros filled from LSB (k = 1..WIDTH-1) -> idx WIDTH+k.
  - phase = 1 << phase_idx.
  - Decode is combinational from q; zero latency.
- FSM states: IDLE, RUN.
- IDLE:
  - stop=1 -> start ignored (stop wins); no pulse.
  - Else start=1, mode=0, steps=N>0 -> latch remaining=N, go to RUN.
  - Else start=1, mode=0, steps=0 -> stay IDLE, done pulses next cycle, q unchanged.
  - Else start=1, mode=1 -> go to RUN (continuous).
  - Else clr=1 -> q<=0.
- Latency, start sampled at edge k:
  - busy=1 from after edge k.
  - q advances on edges k+1 .. k+N.
  - At edge k+N, remaining reaches 0: state<=IDLE, busy<=0, done<=1 for exactly one cycle.
- RUN, one-shot: each cycle q advances, remaining decrements.
- RUN, continuous: q advances every cycle; wraps indefinitely.
- stop=1 in RUN at edge m:
  - q does not advance at edge m.
  - state<=IDLE, busy<=0, aborted pulses one cycle, done not asserted.
  - q holds last value.
- stop on the same edge as the last one-shot step: stop wins; no advance, aborted=1, done=0.
- start/clr while busy: ignored; steps/mode changes mid-run have no effect.
- done and aborted are never high together.
- Next run continues from the held q; no implicit clear.
- Reset mid-run: immediate return to reset values; no pulse on release.
- All outputs registered except phase/phase_idx (decode of registered q).

Decomposition:
- Package johnson_pkg:
  - FSM state enum (IDLE, RUN).
  - function jc_next(q).
  - function jc_idx(q).
- Sub-module johnson_core (clk, rst, en, clr, q): holds q.
  - Advances when en=1; clears when clr=1; clr has priority.
  - Same active-low async reset.
- Controller contains the FSM, remaining counter, pulses and decode.

Test Plan:
- Reset: hold rst=0 for 3 cycles -> q=0000, phase=00000001, busy=done=aborted=0; release -> outputs unchanged.
- One-shot: start, mode=0, steps=5 at edge k -> busy high 5 cycles, q ends 1110, phase_idx=5, done high exactly 1 cycle at k+5.
- Wrap and continue: from q=1110, one-shot steps=4 -> q passes 1100, 1000, 0000, ends 0001, idx=1, single done pulse.
- Continuous + stop: mode=1 for 11 cycles then stop -> q advanced 11 steps from 0000 to 0111, idx=3, aborted 1 cycle, done=0.
- Boundaries:
  - steps=0 -> done pulse, busy never high, q unchanged.
  - start with stop in IDLE -> nothing happens.
  - stop on last step of steps=3 -> q advanced 2 steps, aborted=1, done=0.
- clr: in IDLE with q=0111, clr=1 -> q=0000 next edge; clr during RUN -> ignored. Mid-run rst=0 -> q=0000, busy=0 asynchronously.
